// File: rtl/mmr_scrub_ctrl.sv
// rtl/mmr_scrub_ctrl.sv - scrub scheduler for TMR/K-MMR register groups
// Periodically scans voter mismatch flags, refreshes flagged groups and re-checks them.
module mmr_scrub_ctrl #(
   parameter int N_REGS        = 8,
   parameter int IDX_W         = $clog2(N_REGS),
   parameter int CNT_W         = 16,
   parameter int SCAN_PERIOD   = 1024,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              clear_i,
   input  logic [N_REGS-1:0] mismatch_i,
   output logic              refresh_req_o,
   output logic [IDX_W-1:0]  refresh_idx_o,
   input  logic              refresh_ack_i,
   output logic              busy_o,
   output logic              scan_done_o,
   output logic [CNT_W-1:0]  seu_count_o,
   output logic [CNT_W-1:0]  stuck_count_o,
   output logic [N_REGS-1:0] stuck_o
);

   localparam int TMR_W = $clog2(SCAN_PERIOD);
   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_REFRESH,
      ST_SETTLE,
      ST_CHECK
   } state_t;

   state_t              state_q, state_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [SET_W-1:0]    settle_q, settle_d;
   logic [CNT_W-1:0]    seu_q, seu_d;
   logic [CNT_W-1:0]    stk_cnt_q, stk_cnt_d;
   logic [N_REGS-1:0]   stuck_q, stuck_d;
   logic                req_q, busy_q, done_q, done_d;
   logic                seu_inc, stk_set, last_idx;

   assign last_idx = (idx_q == IDX_W'(N_REGS - 1));

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      idx_d    = idx_q;
      settle_d = settle_q;
      seu_inc  = 1'b0;
      stk_set  = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!enable_i) begin
               timer_d = '0;
            end else if (timer_q == TMR_W'(SCAN_PERIOD - 1)) begin
               timer_d = '0;
               idx_d   = '0;
               state_d = ST_SCAN;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_SCAN: begin
            if (mismatch_i[idx_q]) begin
               seu_inc = 1'b1;
               state_d = ST_REFRESH;
            end else if (last_idx) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_REFRESH: begin
            if (refresh_ack_i) begin
               settle_d = '0;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
               settle_d = '0;
               state_d  = ST_CHECK;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         ST_CHECK: begin
            stk_set = mismatch_i[idx_q];
            if (last_idx) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = ST_SCAN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Clear has priority over any same-cycle increment or stuck-flag set.
   always_comb begin
      seu_d     = seu_q;
      stk_cnt_d = stk_cnt_q;
      stuck_d   = stuck_q;
      if (clear_i) begin
         seu_d     = '0;
         stk_cnt_d = '0;
         stuck_d   = '0;
      end else begin
         if (seu_inc && !(&seu_q)) seu_d = seu_q + CNT_W'(1);
         if (stk_set) begin
            stuck_d = stuck_q | (N_REGS'(1) << idx_q);
            if (!(&stk_cnt_q)) stk_cnt_d = stk_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         idx_q     <= '0;
         settle_q  <= '0;
         seu_q     <= '0;
         stk_cnt_q <= '0;
         stuck_q   <= '0;
         req_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         idx_q     <= idx_d;
         settle_q  <= settle_d;
         seu_q     <= seu_d;
         stk_cnt_q <= stk_cnt_d;
         stuck_q   <= stuck_d;
         req_q     <= (state_d == ST_REFRESH);
         busy_q    <= (state_d != ST_IDLE);
         done_q    <= done_d;
      end
   end

   assign refresh_req_o = req_q;
   assign refresh_idx_o = idx_q;
   assign busy_o        = busy_q;
   assign scan_done_o   = done_q;
   assign seu_count_o   = seu_q;
   assign stuck_count_o = stk_cnt_q;
   assign stuck_o       = stuck_q;

endmodule

// File: doc/mmr_scrub_ctrl.md
# mmr_scrub_ctrl

Scrub scheduler for a bank of TMR/K-MMR register groups. It periodically scans the per-group voter mismatch flags. For each flagged group it requests a refresh, which rewrites all replicas from the voted value, then re-checks the group after a settle time. It counts transient upsets and persistent (stuck) mismatches, and sits between the register-bank mismatch outputs and the slow-control status registers.

## Interface
- N_REGS, 8: number of register groups scanned; legal range 2..64.
- IDX_W, $clog2(N_REGS): derived width of the group index; not overridden.
- CNT_W, 16: width of the saturating event counters.
- SCAN_PERIOD, 1024: cycles spent in IDLE between scans; ≥ 2.
- SETTLE_CYCLES, 2: wait after a refresh ack before the re-check; ≥ 1.

- clk_i  in  1  single clock for all logic.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  enables the IDLE period timer.
- clear_i  in  1  zeroes the counters and stuck flags.
- mismatch_i  in  N_REGS  per-group mismatch flags (level, from voter OR-reduction).
- refresh_req_o  out  1  refresh request for group refresh_idx_o.
- refresh_idx_o  out  IDX_W  group being scanned or refreshed.
- refresh_ack_i  in  1  refresh performed; sampled only in REFRESH.
- busy_o  out  1  high whenever state ≠ IDLE.
- scan_done_o  out  1  one-cycle pulse at end of each full scan.
- seu_count_o  out  CNT_W  mismatches detected during scans; saturating.
- stuck_count_o  out  CNT_W  mismatches still present after refresh; saturating.
- stuck_o  out  N_REGS  sticky per-group persistent-mismatch flag.

## Operation
- State machine: IDLE, SCAN, REFRESH, SETTLE, CHECK. All outputs are registered.
- IDLE
  - Timer increments while enable_i=1 and holds at 0 while enable_i=0.
  - When timer = SCAN_PERIOD-1: clear timer, idx←0, next state SCAN.
- SCAN
  - Examines mismatch_i[idx], one group per cycle.
  - Flag set: seu_count+1 (saturating at all-ones), next state REFRESH with idx held.
  - Flag clear and idx = N_REGS-1: next state IDLE, scan_done_o=1 in that first IDLE cycle.
  - Flag clear otherwise: idx+1.
- REFRESH
  - refresh_req_o=1, refresh_idx_o=idx, held stable until refresh_ack_i is sampled high.
  - No timeout: a missing ack holds the FSM in REFRESH indefinitely.
- SETTLE
  - Lasts exactly SETTLE_CYCLES cycles, counted by a settle counter, then CHECK.
- CHECK
  - Re-samples mismatch_i[idx]. If still set: stuck_o[idx]←1, stuck_count+1 (saturating).
  - Then idx = N_REGS-1 → IDLE with scan_done_o pulse; else idx+1 → SCAN.
- enable_i only gates the IDLE timer. Dropping enable_i mid-scan does not abort the scan or a pending handshake.
- clear_i
  - Zeroes seu_count_o, stuck_count_o and stuck_o in the next cycle.
  - Clear wins over a simultaneous increment or stuck set.
  - Does not affect the FSM, idx or timer.
- refresh_ack_i outside REFRESH is ignored.
- mismatch_i is not sampled outside SCAN/CHECK; a flag that rises and falls between visits is missed by design.

## Timing
- Reset: state IDLE, timer 0, idx 0, settle counter 0, and all outputs 0 (refresh_req_o, refresh_idx_o, busy_o, scan_done_o, both counters, stuck_o).
- Reset mid-handshake drops refresh_req_o in the cycle after rst_i is sampled. No ack is awaited.
- IDLE lasts SCAN_PERIOD cycles with enable_i held high.
- Error-free scan: N_REGS SCAN cycles. Scan-start to scan-start period = SCAN_PERIOD + N_REGS cycles.
- Mismatch seen in SCAN at cycle t:
  - seu_count_o updated and refresh_req_o high at t+1.
  - Ack sampled at cycle k ≥ t+1: refresh_req_o low at k+1; SETTLE occupies k+1 … k+SETTLE_CYCLES; CHECK at k+SETTLE_CYCLES+1.
  - Next group is scanned in the following cycle.
- Ack high in the first REFRESH cycle is legal: zero-wait handshake.
- refresh_idx_o tracks idx in SCAN as well. It is qualified only by refresh_req_o.

## Test plan
- Reset, enable_i=1, mismatch_i=0, N_REGS=8, SCAN_PERIOD=16 → scan_done_o pulses every 24 cycles; refresh_req_o never high; counters stay 0.
- mismatch_i[3]=1 that clears 1 cycle after ack → one refresh with refresh_idx_o=3; seu_count_o=1; stuck_count_o=0; stuck_o=0.
- mismatch_i[5] stuck at 1, ack delayed 4 cycles → refresh_req_o high exactly 5 cycles; CHECK at ack+3 (SETTLE_CYCLES=2); stuck_o[5]=1; stuck_count_o=1; next scan increments both counters again.
- CNT_W=4 with a permanent mismatch over 20 scans → seu_count_o and stuck_count_o saturate at 15.
- clear_i pulsed in the same cycle as a CHECK stuck detection → counters and stuck_o read 0 next cycle; FSM continues scan normally.
- rst_i asserted while refresh_req_o=1 → refresh_req_o=0, busy_o=0 next cycle; IDLE timer restarts from 0.
